// File: rtl/reset_sequencer_pkg.sv
// Shared state encodings and sizing helper for the reset sequencer and the
// link-level monitor that decodes its state.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Handshake bundle between the reset sequencer (slave) and the per-domain
// logic it controls (master drives requests and ready, observes resets).
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3
) ();

  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  seq_done;
  logic                  soft_rst_ack;
  logic                  timeout_err;

  modport master (
    output soft_rst_req, stage_ready,
    input  rst_out, seq_done, soft_rst_ack, timeout_err
  );

  modport slave (
    input  soft_rst_req, stage_ready,
    output rst_out, seq_done, soft_rst_ack, timeout_err
  );

endinterface

// File: rtl/reset_sequencer.sv
// Ordered per-domain reset release: hold all domains, then free stage 0..N-1
// one at a time, each gated on its ready input, with timeout retry and soft reset.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGE_GAP      = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              rst,
  reset_sequencer_if.slave bus
);

  localparam int CW = $clog2(max_int(HOLD_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_STAGES - 1);

  seq_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
  logic                  seq_done_q, seq_done_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  soft_accept;
  logic                  timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HOLD;
      cnt_q      <= '0;
      idx_q      <= '0;
      rst_out_q  <= '1;
      seq_done_q <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      rst_out_q  <= rst_out_d;
      seq_done_q <= seq_done_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  // Soft request outranks advance, timeout and lost-ready in WAIT/RUN.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    soft_accept = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      HOLD: begin
        if (bus.soft_rst_req) begin
          cnt_d = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        if (bus.soft_rst_req) begin
          state_d     = HOLD;
          cnt_d       = '0;
          idx_d       = '0;
          soft_accept = 1'b1;
        end else if (bus.stage_ready[idx_q] && (cnt_q >= GAP_LAST)) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          state_d     = HOLD;
          cnt_d       = '0;
          idx_d       = '0;
          timeout_hit = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (bus.soft_rst_req) begin
          state_d     = HOLD;
          idx_d       = '0;
          soft_accept = 1'b1;
        end else if (!(&bus.stage_ready)) begin
          state_d = HOLD;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so they register in step with it.
  always_comb begin
    rst_out_d  = '1;
    seq_done_d = 1'b0;
    ack_d      = soft_accept;
    err_d      = err_q | timeout_hit;
    case (state_d)
      WAIT: begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          rst_out_d[i] = (i > int'(idx_d));
        end
      end
      RUN: begin
        rst_out_d  = '0;
        seq_done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.rst_out      = rst_out_q;
  assign bus.seq_done     = seq_done_q;
  assign bus.soft_rst_ack = ack_q;
  assign bus.timeout_err  = err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a 3-stage instance for sequencing,
// timeout, soft reset and lost-ready, plus a minimal 1-stage instance.
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   ack_count;

  always #5 clk = ~clk;

  reset_sequencer_if #(.NUM_STAGES(3)) bus3 ();
  reset_sequencer_if #(.NUM_STAGES(1)) bus1 ();

  reset_sequencer #(
    .NUM_STAGES(3), .HOLD_CYCLES(16), .STAGE_GAP(8), .TIMEOUT_CYCLES(64)
  ) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  reset_sequencer #(
    .NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .TIMEOUT_CYCLES(64)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (edge %0d)", tag, actual, expected, edge_n);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [2:0] ready);
    bus3.soft_rst_req = req;
    bus3.stage_ready  = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  // Expected release schedule counted from the edge that entered HOLD (edge 0).
  task automatic verify_sequence(input string name);
    run_to(15);
    checkOutput({name, "_e15_rst_out"}, 32'(bus3.rst_out), 32'h7);
    run_to(16);
    checkOutput({name, "_e16_rst_out"}, 32'(bus3.rst_out), 32'h6);
    run_to(23);
    checkOutput({name, "_e23_rst_out"}, 32'(bus3.rst_out), 32'h6);
    run_to(24);
    checkOutput({name, "_e24_rst_out"}, 32'(bus3.rst_out), 32'h4);
    run_to(31);
    checkOutput({name, "_e31_rst_out"}, 32'(bus3.rst_out), 32'h4);
    run_to(32);
    checkOutput({name, "_e32_rst_out"}, 32'(bus3.rst_out), 32'h0);
    checkOutput({name, "_e32_done"}, 32'(bus3.seq_done), 32'h0);
    run_to(39);
    checkOutput({name, "_e39_done"}, 32'(bus3.seq_done), 32'h0);
    run_to(40);
    checkOutput({name, "_e40_done"}, 32'(bus3.seq_done), 32'h1);
    checkOutput({name, "_e40_rst_out"}, 32'(bus3.rst_out), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 3'b111);
    bus1.soft_rst_req = 1'b0;
    bus1.stage_ready  = 1'b1;
    repeat (4) tick();
    checkOutput("reset_rst_out", 32'(bus3.rst_out), 32'h7);
    checkOutput("reset_done", 32'(bus3.seq_done), 32'h0);
    checkOutput("reset_ack", 32'(bus3.soft_rst_ack), 32'h0);
    checkOutput("reset_err", 32'(bus3.timeout_err), 32'h0);
    checkOutput("reset_rst_out_1st", 32'(bus1.rst_out), 32'h1);

    $display("[TB] basic sequence after reset");
    rst    = 1'b0;
    edge_n = 0;
    run_to(1);
    checkOutput("one_stage_e1_rst_out", 32'(bus1.rst_out), 32'h0);
    checkOutput("one_stage_e1_done", 32'(bus1.seq_done), 32'h0);
    run_to(2);
    checkOutput("one_stage_e2_done", 32'(bus1.seq_done), 32'h1);
    verify_sequence("seq");

    $display("[TB] single-cycle soft reset in RUN");
    applyStimulus(1'b1, 3'b111);
    tick();
    edge_n = 0;
    checkOutput("soft_ack_high", 32'(bus3.soft_rst_ack), 32'h1);
    checkOutput("soft_rst_out", 32'(bus3.rst_out), 32'h7);
    checkOutput("soft_done", 32'(bus3.seq_done), 32'h0);
    applyStimulus(1'b0, 3'b111);
    tick();
    checkOutput("soft_ack_low", 32'(bus3.soft_rst_ack), 32'h0);
    verify_sequence("soft");

    $display("[TB] held soft reset in RUN");
    ack_count = 0;
    applyStimulus(1'b1, 3'b111);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus3.soft_rst_ack) ack_count++;
    end
    checkOutput("held_ack_count", 32'(ack_count), 32'h1);
    checkOutput("held_rst_out", 32'(bus3.rst_out), 32'h7);
    applyStimulus(1'b0, 3'b111);
    edge_n = 0;
    verify_sequence("held");

    $display("[TB] lost ready in RUN");
    applyStimulus(1'b0, 3'b110);
    tick();
    edge_n = 0;
    checkOutput("lost_rst_out", 32'(bus3.rst_out), 32'h7);
    checkOutput("lost_done", 32'(bus3.seq_done), 32'h0);
    checkOutput("lost_ack", 32'(bus3.soft_rst_ack), 32'h0);
    applyStimulus(1'b0, 3'b111);
    verify_sequence("lost");

    $display("[TB] reset with soft request mid-WAIT");
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    edge_n = 0;
    run_to(20);
    checkOutput("midwait_rst_out_before", 32'(bus3.rst_out), 32'h6);
    applyStimulus(1'b1, 3'b111);
    rst = 1'b1;
    tick();
    checkOutput("midwait_rst_out", 32'(bus3.rst_out), 32'h7);
    checkOutput("midwait_done", 32'(bus3.seq_done), 32'h0);
    checkOutput("midwait_ack", 32'(bus3.soft_rst_ack), 32'h0);
    tick();
    checkOutput("midwait_ack_again", 32'(bus3.soft_rst_ack), 32'h0);

    $display("[TB] stage timeout and retry");
    applyStimulus(1'b0, 3'b101);
    rst    = 1'b0;
    edge_n = 0;
    run_to(16);
    checkOutput("to_e16_rst_out", 32'(bus3.rst_out), 32'h6);
    run_to(24);
    checkOutput("to_e24_rst_out", 32'(bus3.rst_out), 32'h4);
    run_to(32);
    checkOutput("to_e32_rst_out", 32'(bus3.rst_out), 32'h4);
    run_to(87);
    checkOutput("to_e87_rst_out", 32'(bus3.rst_out), 32'h4);
    checkOutput("to_e87_err", 32'(bus3.timeout_err), 32'h0);
    run_to(88);
    checkOutput("to_e88_rst_out", 32'(bus3.rst_out), 32'h7);
    checkOutput("to_e88_err", 32'(bus3.timeout_err), 32'h1);
    edge_n = 0;
    run_to(16);
    checkOutput("retry_e16_rst_out", 32'(bus3.rst_out), 32'h6);
    checkOutput("retry_e16_err", 32'(bus3.timeout_err), 32'h1);
    applyStimulus(1'b0, 3'b111);
    run_to(24);
    checkOutput("retry_e24_rst_out", 32'(bus3.rst_out), 32'h4);
    run_to(32);
    checkOutput("retry_e32_rst_out", 32'(bus3.rst_out), 32'h0);
    run_to(40);
    checkOutput("retry_e40_done", 32'(bus3.seq_done), 32'h1);
    checkOutput("retry_e40_err", 32'(bus3.timeout_err), 32'h1);
    rst = 1'b1;
    tick();
    checkOutput("err_cleared_by_rst", 32'(bus3.timeout_err), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
